// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use detection, bubble insertion, branch flush and WB-to-ID bypass
// Ports: clk/rst (sync, active-high); stall_ext freezes everything; flush_ex squashes the ID instruction;
//        *_ID decoded fields in, *_EX registered copies out; rd_WB/RegWEn_WB/wb_data_WB feed the bypass;
//        pc_write_en/ifid_write_en hold the front end; load_use_stall is combinational; stall_cnt/flush_cnt saturate.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_ext,
    input  logic            flush_ex,
    input  logic            valid_ID,
    input  logic [4:0]      rs1_ID,
    input  logic [4:0]      rs2_ID,
    input  logic [4:0]      rd_ID,
    input  logic            uses_rs1_ID,
    input  logic            uses_rs2_ID,
    input  logic [XLEN-1:0] rs1_data_ID,
    input  logic [XLEN-1:0] rs2_data_ID,
    input  logic [XLEN-1:0] imm_ID,
    input  logic [XLEN-1:0] pc_ID,
    input  logic            RegWEn_ID,
    input  logic            MemRead_ID,
    input  logic            MemWrite_ID,
    input  logic            ASel_ID,
    input  logic            BSel_ID,
    input  logic [3:0]      ALUSel_ID,
    input  logic [1:0]      WBSel_ID,
    input  logic [4:0]      rd_WB,
    input  logic            RegWEn_WB,
    input  logic [XLEN-1:0] wb_data_WB,
    output logic            valid_EX,
    output logic [4:0]      rs1_EX,
    output logic [4:0]      rs2_EX,
    output logic [4:0]      rd_EX,
    output logic [XLEN-1:0] rs1_data_EX,
    output logic [XLEN-1:0] rs2_data_EX,
    output logic [XLEN-1:0] imm_EX,
    output logic [XLEN-1:0] pc_EX,
    output logic            RegWEn_EX,
    output logic            MemRead_EX,
    output logic            MemWrite_EX,
    output logic            ASel_EX,
    output logic            BSel_EX,
    output logic [3:0]      ALUSel_EX,
    output logic [1:0]      WBSel_EX,
    output logic            pc_write_en,
    output logic            ifid_write_en,
    output logic            load_use_stall,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    logic hazard, bubble, rs1Fwd, rs2Fwd;
    // A bubble in EX has rd_EX=0, so the x0 check also keeps bubbles from matching.
    assign hazard = valid_EX & MemRead_EX & (rd_EX != 5'd0) & valid_ID &
                    ((uses_rs1_ID & (rs1_ID == rd_EX)) | (uses_rs2_ID & (rs2_ID == rd_EX)));
    assign load_use_stall = hazard & ~flush_ex;
    assign pc_write_en    = ~stall_ext & ~load_use_stall;
    assign ifid_write_en  = ~stall_ext & ~load_use_stall;
    assign bubble = flush_ex | hazard;
    // The register file is read in ID before WB's write lands, so pass the WB value through.
    assign rs1Fwd = RegWEn_WB & (rd_WB != 5'd0) & (rd_WB == rs1_ID);
    assign rs2Fwd = RegWEn_WB & (rd_WB != 5'd0) & (rd_WB == rs2_ID);
    always_ff @(posedge clk) begin
        if (rst || (!stall_ext && bubble)) begin
            valid_EX    <= 1'b0;
            rs1_EX      <= '0;
            rs2_EX      <= '0;
            rd_EX       <= '0;
            rs1_data_EX <= '0;
            rs2_data_EX <= '0;
            imm_EX      <= '0;
            pc_EX       <= '0;
            RegWEn_EX   <= 1'b0;
            MemRead_EX  <= 1'b0;
            MemWrite_EX <= 1'b0;
            ASel_EX     <= 1'b0;
            BSel_EX     <= 1'b0;
            ALUSel_EX   <= '0;
            WBSel_EX    <= '0;
        end else if (!stall_ext) begin
            valid_EX    <= valid_ID;
            rs1_EX      <= rs1_ID;
            rs2_EX      <= rs2_ID;
            rd_EX       <= rd_ID;
            rs1_data_EX <= rs1Fwd ? wb_data_WB : rs1_data_ID;
            rs2_data_EX <= rs2Fwd ? wb_data_WB : rs2_data_ID;
            imm_EX      <= imm_ID;
            pc_EX       <= pc_ID;
            RegWEn_EX   <= RegWEn_ID;
            MemRead_EX  <= MemRead_ID;
            MemWrite_EX <= MemWrite_ID;
            ASel_EX     <= ASel_ID;
            BSel_EX     <= BSel_ID;
            ALUSel_EX   <= ALUSel_ID;
            WBSel_EX    <= WBSel_ID;
        end
    end
    // Flush outranks the hazard, so at most one counter moves per edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (!stall_ext) begin
            if (flush_ex && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
            else if (!flush_ex && hazard && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for id_ex_stage (counters narrowed to 2 bits to reach saturation)
module tb_id_ex_stage;
    localparam int XLEN  = 32;
    localparam int CNT_W = 2;
    logic clk = 1'b0, rst, stall_ext, flush_ex, valid_ID;
    logic [4:0] rs1_ID, rs2_ID, rd_ID, rd_WB;
    logic uses_rs1_ID, uses_rs2_ID, RegWEn_ID, MemRead_ID, MemWrite_ID, ASel_ID, BSel_ID, RegWEn_WB;
    logic [XLEN-1:0] rs1_data_ID, rs2_data_ID, imm_ID, pc_ID, wb_data_WB;
    logic [3:0] ALUSel_ID;
    logic [1:0] WBSel_ID;
    logic valid_EX, RegWEn_EX, MemRead_EX, MemWrite_EX, ASel_EX, BSel_EX;
    logic [4:0] rs1_EX, rs2_EX, rd_EX;
    logic [XLEN-1:0] rs1_data_EX, rs2_data_EX, imm_EX, pc_EX;
    logic [3:0] ALUSel_EX;
    logic [1:0] WBSel_EX;
    logic pc_write_en, ifid_write_en, load_use_stall;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    int tests = 0, fails = 0;
    int expStall;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stall_ext(stall_ext), .flush_ex(flush_ex), .valid_ID(valid_ID),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_ID(rd_ID), .uses_rs1_ID(uses_rs1_ID), .uses_rs2_ID(uses_rs2_ID),
        .rs1_data_ID(rs1_data_ID), .rs2_data_ID(rs2_data_ID), .imm_ID(imm_ID), .pc_ID(pc_ID),
        .RegWEn_ID(RegWEn_ID), .MemRead_ID(MemRead_ID), .MemWrite_ID(MemWrite_ID), .ASel_ID(ASel_ID),
        .BSel_ID(BSel_ID), .ALUSel_ID(ALUSel_ID), .WBSel_ID(WBSel_ID), .rd_WB(rd_WB), .RegWEn_WB(RegWEn_WB),
        .wb_data_WB(wb_data_WB), .valid_EX(valid_EX), .rs1_EX(rs1_EX), .rs2_EX(rs2_EX), .rd_EX(rd_EX),
        .rs1_data_EX(rs1_data_EX), .rs2_data_EX(rs2_data_EX), .imm_EX(imm_EX), .pc_EX(pc_EX),
        .RegWEn_EX(RegWEn_EX), .MemRead_EX(MemRead_EX), .MemWrite_EX(MemWrite_EX), .ASel_EX(ASel_EX),
        .BSel_EX(BSel_EX), .ALUSel_EX(ALUSel_EX), .WBSel_EX(WBSel_EX), .pc_write_en(pc_write_en),
        .ifid_write_en(ifid_write_en), .load_use_stall(load_use_stall), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clearId();
        valid_ID = 0; rs1_ID = 0; rs2_ID = 0; rd_ID = 0; uses_rs1_ID = 0; uses_rs2_ID = 0;
        rs1_data_ID = 0; rs2_data_ID = 0; imm_ID = 0; pc_ID = 0; RegWEn_ID = 0; MemRead_ID = 0;
        MemWrite_ID = 0; ASel_ID = 0; BSel_ID = 0; ALUSel_ID = 0; WBSel_ID = 0;
    endtask

    task automatic loadWord(input logic [4:0] rd, input logic [4:0] rs1);
        clearId();
        valid_ID = 1; rd_ID = rd; rs1_ID = rs1; uses_rs1_ID = 1; MemRead_ID = 1; RegWEn_ID = 1; WBSel_ID = 2'd1;
    endtask

    task automatic addUsing(input logic [4:0] rs1, input logic [4:0] rd);
        clearId();
        valid_ID = 1; rs1_ID = rs1; rd_ID = rd; uses_rs1_ID = 1; uses_rs2_ID = 1; RegWEn_ID = 1;
    endtask

    initial begin
        rst = 1; stall_ext = 0; flush_ex = 0; rd_WB = 0; RegWEn_WB = 0; wb_data_WB = 0;
        clearId();
        valid_ID = 1; rd_ID = 5'd3; RegWEn_ID = 1; pc_ID = 32'h44;
        tick();
        chk("rst_valid", valid_EX, 0);
        chk("rst_rd", rd_EX, 0);
        chk("rst_pc", pc_EX, 0);
        chk("rst_regwen", RegWEn_EX, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);
        rst = 0;

        loadWord(5'd5, 5'd2); pc_ID = 32'h100;
        settle();
        chk("lw_no_stall", load_use_stall, 0);
        chk("lw_pc_we", pc_write_en, 1);
        tick();
        chk("lw_valid_ex", valid_EX, 1);
        chk("lw_memread_ex", MemRead_EX, 1);
        chk("lw_rd_ex", rd_EX, 5);
        chk("lw_pc_ex", pc_EX, 32'h100);

        addUsing(5'd5, 5'd6); uses_rs2_ID = 0; rs2_ID = 5'd9;
        settle();
        chk("lu_stall", load_use_stall, 1);
        chk("lu_pc_we", pc_write_en, 0);
        chk("lu_ifid_we", ifid_write_en, 0);
        tick();
        chk("lu_bubble_valid", valid_EX, 0);
        chk("lu_bubble_regwen", RegWEn_EX, 0);
        chk("lu_bubble_rd", rd_EX, 0);
        chk("lu_stall_cnt", stall_cnt, 1);
        chk("lu_stall_released", load_use_stall, 0);
        chk("lu_pc_we_back", pc_write_en, 1);
        tick();
        chk("lu_add_valid", valid_EX, 1);
        chk("lu_add_rs1", rs1_EX, 5);
        chk("lu_add_rd", rd_EX, 6);
        chk("lu_stall_cnt_hold", stall_cnt, 1);

        loadWord(5'd0, 5'd1);
        tick();
        addUsing(5'd0, 5'd4); uses_rs2_ID = 0;
        settle();
        chk("x0_no_stall", load_use_stall, 0);
        loadWord(5'd5, 5'd0);
        tick();
        clearId(); valid_ID = 1; rs1_ID = 5'd1; uses_rs1_ID = 1; rs2_ID = 5'd5; uses_rs2_ID = 0; rd_ID = 5'd8;
        settle();
        chk("unused_rs2_no_stall", load_use_stall, 0);
        chk("unused_rs2_pc_we", pc_write_en, 1);
        uses_rs2_ID = 1;
        settle();
        chk("used_rs2_stall", load_use_stall, 1);

        flush_ex = 1;
        settle();
        chk("flush_beats_hz", load_use_stall, 0);
        chk("flush_pc_we", pc_write_en, 1);
        tick();
        flush_ex = 0;
        chk("flush_bubble_valid", valid_EX, 0);
        chk("flush_bubble_rd", rd_EX, 0);
        chk("flush_cnt_1", flush_cnt, 1);
        chk("flush_stall_cnt_same", stall_cnt, 1);

        clearId(); valid_ID = 1; rd_ID = 5'd9; RegWEn_ID = 1; pc_ID = 32'h200; imm_ID = 32'h33;
        ALUSel_ID = 4'hA; WBSel_ID = 2'd2; ASel_ID = 1;
        tick();
        chk("pre_freeze_rd", rd_EX, 9);
        stall_ext = 1; flush_ex = 1;
        clearId(); valid_ID = 1; rd_ID = 5'd3; pc_ID = 32'h300;
        settle();
        chk("freeze_pc_we", pc_write_en, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("freeze_rd", rd_EX, 9);
            chk("freeze_pc", pc_EX, 32'h200);
            chk("freeze_valid", valid_EX, 1);
            chk("freeze_alusel", ALUSel_EX, 4'hA);
            chk("freeze_flush_cnt", flush_cnt, 1);
        end
        stall_ext = 0;
        tick();
        flush_ex = 0;
        chk("release_flush_valid", valid_EX, 0);
        chk("release_flush_pc", pc_EX, 0);
        chk("release_flush_cnt", flush_cnt, 2);

        clearId(); valid_ID = 1; rs1_ID = 5'd7; rs1_data_ID = 32'h11; rs2_ID = 5'd7; rs2_data_ID = 32'h0;
        RegWEn_WB = 1; rd_WB = 5'd7; wb_data_WB = 32'hDEADBEEF;
        tick();
        chk("byp_rs2", rs2_data_EX, 32'hDEADBEEF);
        chk("byp_rs1", rs1_data_EX, 32'hDEADBEEF);
        rs1_ID = 5'd8; rd_WB = 5'd0;
        tick();
        chk("byp_x0_rs2", rs2_data_EX, 32'h0);
        chk("byp_nomatch_rs1", rs1_data_EX, 32'h11);
        rd_WB = 5'd7; RegWEn_WB = 0; rs2_data_ID = 32'h55;
        tick();
        chk("byp_nowen_rs2", rs2_data_EX, 32'h55);
        RegWEn_WB = 0; rd_WB = 0; wb_data_WB = 0;

        expStall = 1;
        for (int i = 0; i < 5; i++) begin
            loadWord(5'd5, 5'd1);
            tick();
            addUsing(5'd5, 5'd6);
            settle();
            chk("sat_hz", load_use_stall, 1);
            tick();
            expStall = (expStall == 3) ? 3 : expStall + 1;
            chk("sat_stall_cnt", stall_cnt, expStall);
        end
        loadWord(5'd5, 5'd1);
        tick();
        loadWord(5'd6, 5'd5);
        settle();
        chk("b2b_load_hz", load_use_stall, 1);
        rst = 1;
        tick();
        rst = 0;
        chk("rst_mid_valid", valid_EX, 0);
        chk("rst_mid_memread", MemRead_EX, 0);
        chk("rst_mid_rd", rd_EX, 0);
        chk("rst_mid_stall_cnt", stall_cnt, 0);
        chk("rst_mid_flush_cnt", flush_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
